// File: rtl/pong_pkg.sv
// Shared game-mode encoding and playfield geometry defaults for the pong datapath.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } game_state_t;

    localparam int unsigned PONG_POS_W      = 10;
    localparam int unsigned PONG_MAX_POS    = 400;
    localparam int unsigned PONG_CENTER_POS = 200;

endpackage

// File: rtl/paddle_axis.sv
// One paddle: saturating detent accumulator, per-frame clamped position update and position register.
module paddle_axis #(
    parameter int unsigned POS_W      = 10,
    parameter int unsigned MAX_POS    = 400,
    parameter int unsigned CENTER_POS = 200,
    parameter int unsigned STEP       = 4,
    parameter int unsigned PEND_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic             load_center,
    output logic [POS_W-1:0] pos
);

    localparam int unsigned EXT_W = POS_W + PEND_W + 2;
    localparam logic signed [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
    localparam logic signed [PEND_W-1:0] PEND_MIN = ~PEND_MAX + PEND_W'(1);
    localparam logic signed [EXT_W-1:0]  STEP_EXT = EXT_W'(STEP);
    localparam logic signed [EXT_W-1:0]  MAX_EXT  = EXT_W'(MAX_POS);

    logic signed [PEND_W-1:0] pend;
    logic signed [PEND_W-1:0] pend_sum;
    logic signed [PEND_W-1:0] pend_seed;
    logic signed [EXT_W-1:0]  pos_ext;
    logic signed [EXT_W-1:0]  pend_ext;
    logic signed [EXT_W-1:0]  sum;
    logic [POS_W-1:0]         pos_new;

    always_comb begin
        pend_sum  = pend;
        pend_seed = '0;
        if (up && !down) begin
            pend_seed = PEND_W'(1);
            if (pend != PEND_MAX) pend_sum = pend + PEND_W'(1);
        end else if (down && !up) begin
            pend_seed = '1;
            if (pend != PEND_MIN) pend_sum = pend - PEND_W'(1);
        end
    end

    always_comb begin
        pos_ext  = {{(PEND_W+2){1'b0}}, pos};
        pend_ext = {{(POS_W+2){pend[PEND_W-1]}}, pend};
        sum      = pos_ext + pend_ext * STEP_EXT;
        if (sum[EXT_W-1])
            pos_new = '0;
        else if (sum > MAX_EXT)
            pos_new = POS_W'(MAX_POS);
        else
            pos_new = sum[POS_W-1:0];
    end

    // A detent arriving with frame_tick misses this update and seeds the next accumulation.
    always_ff @(posedge clk) begin
        if (rst || load_center) begin
            pos  <= POS_W'(CENTER_POS);
            pend <= '0;
        end else if (!enable) begin
            pend <= '0;
        end else if (frame_tick) begin
            pos  <= pos_new;
            pend <= pend_seed;
        end else begin
            pend <= pend_sum;
        end
    end

endmodule

// File: rtl/paddle_controller.sv
// Debounces the two push-switches, runs the idle/serve/play/pause FSM and drives both paddle axes.
module paddle_controller
    import pong_pkg::*;
#(
    parameter int unsigned POS_W           = PONG_POS_W,
    parameter int unsigned MAX_POS         = PONG_MAX_POS,
    parameter int unsigned CENTER_POS      = PONG_CENTER_POS,
    parameter int unsigned STEP            = 4,
    parameter int unsigned PEND_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             p1_up,
    input  logic             p1_down,
    input  logic             p1_sw,
    input  logic             p2_up,
    input  logic             p2_down,
    input  logic             p2_sw,
    input  logic             point_scored,
    input  logic             game_over,
    output logic [POS_W-1:0] p1_pos,
    output logic [POS_W-1:0] p2_pos,
    output logic             pos_valid,
    output logic [1:0]       game_state,
    output logic             serve_req
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             p1_acc, p2_acc;
    logic [CNT_W-1:0] p1_cnt, p2_cnt;
    logic             p1_press, p2_press;
    logic             btn_any;

    game_state_t state, state_next;
    logic        active, apply, load_center, serve_req_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_acc   <= 1'b0;
            p1_cnt   <= '0;
            p1_press <= 1'b0;
        end else begin
            p1_press <= 1'b0;
            if (p1_sw == p1_acc) begin
                p1_cnt <= '0;
            end else if (p1_cnt == DEB_LAST) begin
                p1_acc   <= p1_sw;
                p1_cnt   <= '0;
                p1_press <= p1_sw;
            end else begin
                p1_cnt <= p1_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p2_acc   <= 1'b0;
            p2_cnt   <= '0;
            p2_press <= 1'b0;
        end else begin
            p2_press <= 1'b0;
            if (p2_sw == p2_acc) begin
                p2_cnt <= '0;
            end else if (p2_cnt == DEB_LAST) begin
                p2_acc   <= p2_sw;
                p2_cnt   <= '0;
                p2_press <= p2_sw;
            end else begin
                p2_cnt <= p2_cnt + CNT_W'(1);
            end
        end
    end

    assign btn_any = p1_press | p2_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos_valid <= 1'b0;
            serve_req <= 1'b0;
        end else begin
            state     <= state_next;
            pos_valid <= apply;
            serve_req <= serve_req_d;
        end
    end

    always_comb begin
        state_next = state;
        if (game_over) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (btn_any) state_next = SERVE;
                SERVE:   if (frame_tick) state_next = PLAY;
                PLAY: begin
                    if (point_scored)  state_next = SERVE;
                    else if (btn_any)  state_next = PAUSE;
                end
                PAUSE:   if (btn_any) state_next = PLAY;
                default: state_next = IDLE;
            endcase
        end
    end

    // game_over recentres the paddles, so a coincident frame update is dropped.
    always_comb begin
        active      = (state == SERVE) || (state == PLAY);
        apply       = frame_tick && active && !game_over;
        load_center = (state_next == IDLE);
        serve_req_d = (state_next == SERVE) && (state != SERVE);
    end

    assign game_state = state;

    paddle_axis #(
        .POS_W      (POS_W),
        .MAX_POS    (MAX_POS),
        .CENTER_POS (CENTER_POS),
        .STEP       (STEP),
        .PEND_W     (PEND_W)
    ) u_p1_axis (
        .clk         (clk),
        .rst         (rst),
        .up          (p1_up),
        .down        (p1_down),
        .frame_tick  (apply),
        .enable      (active),
        .load_center (load_center),
        .pos         (p1_pos)
    );

    paddle_axis #(
        .POS_W      (POS_W),
        .MAX_POS    (MAX_POS),
        .CENTER_POS (CENTER_POS),
        .STEP       (STEP),
        .PEND_W     (PEND_W)
    ) u_p2_axis (
        .clk         (clk),
        .rst         (rst),
        .up          (p2_up),
        .down        (p2_down),
        .frame_tick  (apply),
        .enable      (active),
        .load_center (load_center),
        .pos         (p2_pos)
    );

endmodule

// File: tb/tb_paddle_controller.sv
// Bench for paddle_controller: directed scenarios with literal expectations plus randomized traffic vs a cycle model.
module tb_paddle_controller;

    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       p1_up = 1'b0, p1_down = 1'b0, p1_sw = 1'b0;
    logic       p2_up = 1'b0, p2_down = 1'b0, p2_sw = 1'b0;
    logic       point_scored = 1'b0, game_over = 1'b0;
    logic [9:0] p1_pos, p2_pos;
    logic       pos_valid, serve_req;
    logic [1:0] game_state;

    int n_cmp = 0;
    int n_fail = 0;

    paddle_controller #(
        .POS_W           (10),
        .MAX_POS         (400),
        .CENTER_POS      (200),
        .STEP            (4),
        .PEND_W          (4),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .p1_up        (p1_up),
        .p1_down      (p1_down),
        .p1_sw        (p1_sw),
        .p2_up        (p2_up),
        .p2_down      (p2_down),
        .p2_sw        (p2_sw),
        .point_scored (point_scored),
        .game_over    (game_over),
        .p1_pos       (p1_pos),
        .p2_pos       (p2_pos),
        .pos_valid    (pos_valid),
        .game_state   (game_state),
        .serve_req    (serve_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit live = 0;
    int m_st = 0;
    int m_pos[2];
    int m_pend[2];
    int m_acc[2];
    int m_run[2];
    int m_press[2];
    int m_pv = 0;
    int m_sr = 0;

    always @(posedge clk) begin
        int sw[2], d[2], newpress[2];
        int btn, act, app, nst, np;
        sw[0] = int'(p1_sw);
        sw[1] = int'(p2_sw);
        d[0]  = int'(p1_up) - int'(p1_down);
        d[1]  = int'(p2_up) - int'(p2_down);
        if (rst) begin
            live = 1;
            m_st = 0; m_pv = 0; m_sr = 0;
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = 200; m_pend[i] = 0;
                m_acc[i] = 0; m_run[i] = 0; m_press[i] = 0;
            end
        end else if (live) begin
            btn = m_press[0] | m_press[1];
            for (int i = 0; i < 2; i++) begin
                newpress[i] = 0;
                if (sw[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = sw[i];
                        m_run[i] = 0;
                        newpress[i] = sw[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_press = newpress;
            act = (m_st == 1 || m_st == 2) ? 1 : 0;
            app = (frame_tick && act && !game_over) ? 1 : 0;
            nst = m_st;
            if (game_over) nst = 0;
            else if (m_st == 0 && btn) nst = 1;
            else if (m_st == 1 && frame_tick) nst = 2;
            else if (m_st == 2 && point_scored) nst = 1;
            else if (m_st == 2 && btn) nst = 3;
            else if (m_st == 3 && btn) nst = 2;
            for (int i = 0; i < 2; i++) begin
                if (nst == 0) begin
                    m_pos[i] = 200; m_pend[i] = 0;
                end else if (!act) begin
                    m_pend[i] = 0;
                end else if (app) begin
                    np = m_pos[i] + m_pend[i] * 4;
                    if (np < 0) np = 0;
                    if (np > 400) np = 400;
                    m_pos[i] = np;
                    m_pend[i] = d[i];
                end else begin
                    m_pend[i] += d[i];
                    if (m_pend[i] > 7) m_pend[i] = 7;
                    if (m_pend[i] < -7) m_pend[i] = -7;
                end
            end
            m_pv = app;
            m_sr = (nst == 1 && m_st != 1) ? 1 : 0;
            m_st = nst;
        end
        #1;
        if (live) begin
            chk("model_p1_pos", int'(p1_pos), m_pos[0]);
            chk("model_p2_pos", int'(p2_pos), m_pos[1]);
            chk("model_pos_valid", int'(pos_valid), m_pv);
            chk("model_game_state", int'(game_state), m_st);
            chk("model_serve_req", int'(serve_req), m_sr);
        end
    end

    // ---------------- stimulus helpers ----------------
    // v = {p1_up, p1_down, p2_up, p2_down, frame_tick}, held for one cycle
    task automatic cyc(input logic [4:0] v);
        {p1_up, p1_down, p2_up, p2_down, frame_tick} = v;
        @(negedge clk);
        {p1_up, p1_down, p2_up, p2_down, frame_tick} = '0;
    endtask

    task automatic press1();
        p1_sw = 1'b1;
        repeat (DEB + 3) @(negedge clk);
        p1_sw = 1'b0;
        repeat (DEB + 3) @(negedge clk);
    endtask

    initial begin
        bit got;
        int hold1, hold2;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", int'(game_state), 0);
        chk("reset_p1_pos", int'(p1_pos), 200);
        chk("reset_p2_pos", int'(p2_pos), 200);
        chk("reset_pos_valid", int'(pos_valid), 0);
        chk("reset_serve_req", int'(serve_req), 0);

        // Debounced press leaves IDLE.
        p1_sw = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (game_state == 2'd1) got = 1;
        end
        chk("enter_serve", int'(got), 1);
        chk("serve_req_on", int'(serve_req), 1);
        @(negedge clk);
        chk("serve_req_off", int'(serve_req), 0);
        p1_sw = 1'b0;
        repeat (DEB + 3) @(negedge clk);

        cyc(5'b00001);
        chk("serve_to_play", int'(game_state), 2);
        chk("first_frame_valid", int'(pos_valid), 1);
        chk("first_frame_p1", int'(p1_pos), 200);
        @(negedge clk);
        chk("valid_one_cycle", int'(pos_valid), 0);

        // Three detents then a frame.
        repeat (3) cyc(5'b10000);
        cyc(5'b00001);
        chk("p1_three_up", int'(p1_pos), 212);
        chk("p2_untouched", int'(p2_pos), 200);
        chk("three_up_valid", int'(pos_valid), 1);

        // Coincident strobe seeds next frame; up+down cancels.
        repeat (2) cyc(5'b10000);
        cyc(5'b10001);
        chk("coincident_excluded", int'(p1_pos), 220);
        cyc(5'b00001);
        chk("coincident_seeded", int'(p1_pos), 224);
        cyc(5'b11000);
        cyc(5'b00001);
        chk("updown_cancel", int'(p1_pos), 224);

        // Saturation and clamping.
        repeat (20) cyc(5'b00010);
        cyc(5'b00001);
        chk("p2_sat_first", int'(p2_pos), 172);
        repeat (7) begin
            repeat (20) cyc(5'b00010);
            cyc(5'b00001);
        end
        chk("p2_clamp_zero", int'(p2_pos), 0);
        repeat (7) begin
            repeat (20) cyc(5'b10000);
            cyc(5'b00001);
        end
        chk("p1_clamp_max", int'(p1_pos), 400);

        // Pause freezes the paddles.
        press1();
        chk("play_to_pause", int'(game_state), 3);
        repeat (3) cyc(5'b00100);
        cyc(5'b00001);
        chk("pause_no_valid", int'(pos_valid), 0);
        chk("pause_no_move", int'(p2_pos), 0);
        press1();
        chk("pause_to_play", int'(game_state), 2);
        cyc(5'b00001);
        chk("resume_pending_clear", int'(p2_pos), 0);
        chk("resume_valid", int'(pos_valid), 1);

        p1_sw = 1'b1;
        repeat (4) @(negedge clk);
        p1_sw = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_ignored", int'(game_state), 2);

        // game_over beats point_scored.
        repeat (5) cyc(5'b10000);
        point_scored = 1'b1;
        game_over = 1'b1;
        @(negedge clk);
        point_scored = 1'b0;
        game_over = 1'b0;
        chk("gameover_idle", int'(game_state), 0);
        chk("gameover_p1_center", int'(p1_pos), 200);
        chk("gameover_p2_center", int'(p2_pos), 200);
        chk("gameover_no_serve", int'(serve_req), 0);

        // Reset mid-play discards pending.
        press1();
        cyc(5'b00001);
        chk("replay", int'(game_state), 2);
        repeat (5) cyc(5'b10000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(5'b00001);
        chk("rst_no_valid", int'(pos_valid), 0);
        chk("rst_idle", int'(game_state), 0);
        chk("rst_p1_center", int'(p1_pos), 200);

        // Randomized traffic, checked by the model every cycle.
        hold1 = 0;
        hold2 = 0;
        for (int n = 0; n < 5000; n++) begin
            if (hold1 == 0) begin
                p1_sw = 1'($urandom_range(0, 1));
                hold1 = $urandom_range(1, 24);
            end
            if (hold2 == 0) begin
                p2_sw = 1'($urandom_range(0, 1));
                hold2 = $urandom_range(1, 24);
            end
            hold1--;
            hold2--;
            p1_up        = ($urandom_range(0, 2) == 0);
            p1_down      = ($urandom_range(0, 2) == 0);
            p2_up        = ($urandom_range(0, 2) == 0);
            p2_down      = ($urandom_range(0, 2) == 0);
            frame_tick   = ($urandom_range(0, 15) == 0);
            point_scored = ($urandom_range(0, 80) == 0);
            game_over    = ($urandom_range(0, 400) == 0);
            rst          = ($urandom_range(0, 1500) == 0);
            @(negedge clk);
        end
        {p1_up, p1_down, p2_up, p2_down, frame_tick} = '0;
        {point_scored, game_over, rst, p1_sw, p2_sw} = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
